// File: rtl/execute_stage.sv
// execute_stage: E stage of the 5-stage RISC-V pipeline.
// Operand forwarding, ALU, branch/jump resolution and redirect target.
// Optional iterative shift-add multiplier, enabled by defining EXEC_MUL_EN.
// Without the macro, BusyE is tied low and MulE is ignored.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            lui_selE,
  input  logic            jalr_selE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            bne_selE,
  input  logic            MulE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ExtImmE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic            BusyE
);

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_mul_result;
  logic            w_mul_done;
  logic            w_zero;

  // Forwarding muxes; select 11 falls back to the register-file value
  always_comb begin
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultM;
      default: w_src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = ALUResultM;
      default: w_write_data = RD2E;
    endcase
  end

  assign w_src_b    = ALUSrcE ? ExtImmE : w_write_data;
  assign WriteDataE = w_write_data;
  assign w_diff     = w_src_a - w_src_b;
  assign w_zero     = (w_diff == '0);

  // ALU operation decode
  always_comb begin
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_diff;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b100:  w_alu_result = w_src_a ^ w_src_b;
      3'b101:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      3'b110:  w_alu_result = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
      default: w_alu_result = w_src_a << w_src_b[4:0];
    endcase
  end

  // Result priority: lui immediate, finished product, then ALU
  always_comb begin
    if (lui_selE)
      ALUResultE = ExtImmE;
    else if (w_mul_done)
      ALUResultE = w_mul_result;
    else
      ALUResultE = w_alu_result;
  end

  assign w_jalr_sum = w_src_a + ExtImmE;
  assign PCTargetE  = jalr_selE ? {w_jalr_sum[XLEN-1:1], 1'b0} : (PCE + ExtImmE);
  assign PCSrcE     = JumpE | (BranchE & (w_zero ^ bne_selE));

`ifdef EXEC_MUL_EN
  // state   | meaning
  // S_IDLE  | no multiply in flight; a mul in E issues on the next edge
  // S_RUN   | 32 shift-add iterations, counted by r_cnt
  // S_DONE  | product in r_acc drives ALUResultE for one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mul_state_t;

  mul_state_t      r_state;
  mul_state_t      w_state_nxt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_cnt;
  logic            w_busy;

  // Multiplier state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state and stall decode; DONE ignores MulE so the same mul cannot re-issue
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MulE) begin
          w_busy      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 5'd31)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are captured at issue so later forwarding changes cannot corrupt the product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (MulE) begin
        r_mcand  <= w_src_a;
        r_mplier <= w_src_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
    end else if (r_state == S_RUN) begin
      if (r_mplier[0])
        r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  // Reset forces the stall low even though IDLE with MulE would request it
  assign BusyE        = w_busy & rst;
  assign w_mul_done   = (r_state == S_DONE);
  assign w_mul_result = r_acc;
`else
  logic w_unused;

  assign w_unused     = &{1'b0, clk, rst, MulE};
  assign BusyE        = 1'b0;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver pushes expected outputs per cycle,
// a negedge monitor pops and compares. Multiply sequences run when EXEC_MUL_EN is defined.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, lui_selE, jalr_selE, JumpE, BranchE, bne_selE, MulE;
  logic [31:0] RD1E, RD2E, PCE, ExtImmE, ALUResultM, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE;
  logic        PCSrcE, BusyE;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] tgt;
    logic        pcsrc;
    logic        busy;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .lui_selE(lui_selE),
    .jalr_selE(jalr_selE), .JumpE(JumpE), .BranchE(BranchE), .bne_selE(bne_selE),
    .MulE(MulE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ExtImmE(ExtImmE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
    .PCSrcE(PCSrcE), .BusyE(BusyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return ALUResultM;
    return rd;
  endfunction

  // Reference model: expected outputs from current inputs plus multiplier phase
  task automatic push_exp(input bit busy, input bit done, input logic [31:0] prod);
    exp_t e;
    logic [31:0] a, b, wd, alu;
    a  = fwd(ForwardAE, RD1E);
    wd = fwd(ForwardBE, RD2E);
    b  = ALUSrcE ? ExtImmE : wd;
    case (ALUControlE)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: alu = (a < b) ? 32'd1 : 32'd0;
      default: alu = a << b[4:0];
    endcase
    e.alu   = lui_selE ? ExtImmE : (done ? prod : alu);
    e.wd    = wd;
    e.tgt   = jalr_selE ? ((a + ExtImmE) & 32'hFFFF_FFFE) : (PCE + ExtImmE);
    e.pcsrc = JumpE | (BranchE & ((a == b) ^ bne_selE));
    e.busy  = busy;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("ALUResultE", ALUResultE, m_e.alu);
      chk("WriteDataE", WriteDataE, m_e.wd);
      chk("PCTargetE", PCTargetE, m_e.tgt);
      chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, m_e.pcsrc});
      chk("BusyE", {31'd0, BusyE}, {31'd0, m_e.busy});
    end
  end

  task automatic clear_ctl();
    ALUControlE = 3'd0; ALUSrcE = 1'b0; lui_selE = 1'b0; jalr_selE = 1'b0;
    JumpE = 1'b0; BranchE = 1'b0; bne_selE = 1'b0; MulE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  task automatic rand_inputs(input bit allow_mul);
    ALUControlE = 3'($urandom); ALUSrcE = 1'($urandom);
    lui_selE = ($urandom_range(0, 7) == 0); jalr_selE = 1'($urandom);
    JumpE = ($urandom_range(0, 3) == 0); BranchE = 1'($urandom); bne_selE = 1'($urandom);
    MulE = allow_mul ? 1'($urandom) : 1'b0;
    RD1E = $urandom; RD2E = $urandom; PCE = $urandom; ExtImmE = $urandom;
    ALUResultM = $urandom; ResultW = $urandom;
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      ALUSrcE = 1'b0; ForwardBE = ForwardAE; RD2E = RD1E;
    end
  endtask

  // One directed ALU cycle with immediate SrcB
  task automatic alu_imm(input logic [2:0] op, input logic [31:0] a, input logic [31:0] imm);
    @(posedge clk); #1;
    clear_ctl();
    ALUControlE = op; ALUSrcE = 1'b1; RD1E = a; ExtImmE = imm;
    push_exp(1'b0, 1'b0, 32'd0);
  endtask

  task automatic set_issue(input logic [31:0] a, input logic [31:0] b);
    clear_ctl();
    ALUControlE = 3'($urandom); MulE = 1'b1;
    RD1E = a; RD2E = b; ExtImmE = $urandom; PCE = $urandom;
  endtask

  // mul issued in cycle t: busy t..t+32, product in t+33; optional reset at t+rst_at
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int rst_at);
    logic [31:0] prod;
    int i;
    bit did_rst;
    prod = a * b;
    i = 0;
    did_rst = 1'b0;
    while (i <= 33) begin
      @(posedge clk); #1;
      if (i == 0) begin
        set_issue(a, b);
      end else begin
        RD1E = $urandom; RD2E = $urandom; ResultW = $urandom; ALUResultM = $urandom;
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ALUSrcE = 1'($urandom); ExtImmE = $urandom; ALUControlE = 3'($urandom);
      end
      if (rst_at > 0 && !did_rst && i == rst_at) begin
        rst = 1'b0;
        push_exp(1'b0, 1'b0, 32'd0);
        repeat (2) begin
          @(posedge clk); #1;
          push_exp(1'b0, 1'b0, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_issue(a, b);
        push_exp(1'b1, 1'b0, 32'd0);
        did_rst = 1'b1;
        i = 1;
      end else begin
        push_exp(i < 33, i == 33, prod);
        i++;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_ctl();
    RD1E = '0; RD2E = '0; PCE = '0; ExtImmE = '0; ALUResultM = '0; ResultW = '0;

    // Reset: stall stays low even with MulE high; combinational outputs still live
    repeat (3) begin
      @(posedge clk); #1;
      rand_inputs(1'b0);
      MulE = 1'b1;
      push_exp(1'b0, 1'b0, 32'd0);
    end
    @(posedge clk); #1;
    rand_inputs(1'b0);
    rst = 1'b1;
    push_exp(1'b0, 1'b0, 32'd0);

    // ALU sweep with SrcA all ones
    alu_imm(3'd0, 32'hFFFF_FFFF, 32'd1);
    alu_imm(3'd1, 32'hFFFF_FFFF, 32'd1);
    alu_imm(3'd5, 32'hFFFF_FFFF, 32'd1);
    alu_imm(3'd6, 32'hFFFF_FFFF, 32'd1);
    alu_imm(3'd7, 32'hFFFF_FFFF, 32'd4);
    alu_imm(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    alu_imm(3'd3, 32'hF0F0_1234, 32'h0FF0_0001);
    alu_imm(3'd4, 32'hF0F0_1234, 32'hFFFF_FFFF);

    // Forwarding: 10 -> ALUResultM, 01 -> ResultW, 11 -> RD1E
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      clear_ctl();
      ALUSrcE = 1'b1; ExtImmE = 32'd0;
      RD1E = 32'd1; RD2E = 32'd2; ALUResultM = 32'd5; ResultW = 32'd9;
      ForwardAE = 2'(k); ForwardBE = 2'(3 - k);
      push_exp(1'b0, 1'b0, 32'd0);
    end

    // Branches and jalr
    @(posedge clk); #1;
    clear_ctl();
    ALUControlE = 3'd1; BranchE = 1'b1; RD1E = 32'h55; RD2E = 32'h55;
    PCE = 32'h100; ExtImmE = 32'h20;
    push_exp(1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    bne_selE = 1'b1;
    push_exp(1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    RD2E = 32'h56;
    push_exp(1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    clear_ctl();
    JumpE = 1'b1; jalr_selE = 1'b1; RD1E = 32'h1001; ExtImmE = 32'd2; PCE = 32'h400;
    push_exp(1'b0, 1'b0, 32'd0);

    // Randomized combinational traffic
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
`ifdef EXEC_MUL_EN
      rand_inputs(1'b0);
`else
      rand_inputs(1'b1);
`endif
      push_exp(1'b0, 1'b0, 32'd0);
    end

`ifdef EXEC_MUL_EN
    do_mul(32'h1234_5678, 32'h10, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mul(32'd7, 32'd6, 0);
    do_mul(32'd3, 32'd0, 0);
    do_mul($urandom, $urandom, 10);
    for (int k = 0; k < 4; k++) begin
      do_mul($urandom, $urandom, 0);
      @(posedge clk); #1;
      rand_inputs(1'b0);
      push_exp(1'b0, 1'b0, 32'd0);
    end
`endif

    @(posedge clk); #1;
    clear_ctl();
    push_exp(1'b0, 1'b0, 32'd0);

    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RISC-V pipeline. It sits between the D/E pipeline register and the E/M pipeline register. It consumes the E-side control and data fields, applies hazard-unit forwarding, computes the ALU result, resolves branches and jumps, and produces the redirect target. When enabled, an iterative 32-cycle shift-add multiplier is included; it holds the pipeline through `BusyE` while a `mul` is in progress.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk` input 1: pipeline clock. All state updates on the rising edge.
- `rst` input 1: asynchronous reset, active-low. Assert at 0.
- `ALUControlE` input 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 sll (shift amount is `SrcBE[4:0]`).
- `ALUSrcE` input 1: 1 selects `ExtImmE` as SrcB, 0 selects the forwarded rs2 value.
- `lui_selE` input 1: result is `ExtImmE`.
- `jalr_selE` input 1: jump target is `(SrcA+ExtImmE) & ~1`.
- `JumpE`, `BranchE`, `bne_selE` input 1 each: jump, branch, and branch-on-not-equal flags.
- `MulE` input 1: the instruction in E is `mul` (low 32 bits of the product).
- `RD1E`, `RD2E`, `PCE`, `ExtImmE` input 32 each: operands, PC, and immediate.
- `ForwardAE`, `ForwardBE` input 2 each: 00 selects RD1E/RD2E, 01 selects `ResultW`, 10 selects `ALUResultM`, 11 is treated as 00.
- `ALUResultM`, `ResultW` input 32 each: forwarding sources.
- `ALUResultE` output 32: value written into the E/M register.
- `WriteDataE` output 32: forwarded rs2 value, used for stores.
- `PCTargetE` output 32: redirect address.
- `PCSrcE` output 1: take the redirect.
- `BusyE` output 1: stall F/D/E and insert a bubble into M.

## Operation
- `SrcAE` is `RD1E`, `ResultW`, or `ALUResultM`, selected by `ForwardAE`. `WriteDataE` is selected the same way by `ForwardBE`. `SrcBE` is `ALUSrcE ? ExtImmE : WriteDataE`.
- ALU arithmetic is modulo 2^32.
  - slt: signed compare, result 0 or 1.
  - sltu: unsigned compare, result 0 or 1.
  - `ZeroE` is `(SrcAE - SrcBE) == 0`, regardless of `ALUControlE`.
- Result priority: `lui_selE` first, then the multiplier result (DONE state only), then the ALU result.
- `PCSrcE` is `JumpE | (BranchE & (ZeroE ^ bne_selE))`.
- `PCTargetE` is `jalr_selE ? ((SrcAE+ExtImmE) & ~1) : PCE+ExtImmE`.
- Multiplier FSM states are IDLE, RUN, and DONE.
  - IDLE, with `MulE`=1: `BusyE`=1. On the clock edge, latch `mcand`=SrcAE, `mplier`=SrcBE, `acc`=0, `cnt`=0, and go to RUN.
  - RUN: `BusyE`=1. Each edge:
    - If `mplier[0]`, add `mcand` to `acc`.
    - Shift `mcand` left by 1 and `mplier` right by 1.
    - Increment `cnt`.
    - On the edge where `cnt`==31, go to DONE.
    - The iteration count is fixed at 32; there is no early exit.
  - DONE: `BusyE`=0 and `ALUResultE`=`acc`. Go to IDLE on the next edge unconditionally. `MulE` is still 1 in this state, because it is the same instruction, and it must not restart the FSM.
- Operands are latched at issue, so forwarding-source changes while the pipeline is stalled do not affect the product.
- The hazard unit holds D/E while `BusyE`=1. The E-stage inputs are therefore stable, but the block must not depend on that.

## Timing
- The ALU, forwarding, and branch logic are purely combinational, with zero-cycle latency.
- `BusyE` is combinational from `MulE` and the FSM state.
- A `mul` present in E at cycle t gives:
  - Busy during cycles t through t+32 (33 cycles).
  - Result valid in cycle t+33.
  - The instruction leaves E at the end of t+33.
- A back-to-back `mul` enters E at t+34 and sees IDLE.
- While `rst`=0: state is IDLE, `acc`, `mcand`, `mplier`, and `cnt` are 0, and `BusyE`=0 even if `MulE`=1. Combinational outputs follow their inputs.
- Reset asserted mid-RUN: the FSM returns to IDLE immediately and the partial product is discarded.
- After `rst` deasserts, a `mul` still in E restarts from IDLE on the next edge.
- `PCSrcE` and `PCTargetE` do not depend on the FSM. A `mul` never asserts `JumpE` or `BranchE`.

## Configuration
- Macro: `EXEC_MUL_EN`.
- Defined: the multiplier FSM and datapath are compiled in, and operation is as described above.
- Undefined:
  - No multiplier state is generated.
  - `BusyE` is tied to 0.
  - `MulE` is ignored, so the instruction executes as its `ALUControlE` op.
  - `rst` only affects the (absent) state and has no other effect.

## Test plan
- ALU sweep: SrcA=0xFFFFFFFF, SrcB=1 gives add→0, sub→0xFFFFFFFE, slt→1, sltu→0; sll with SrcB=4 gives 0xFFFFFFF0.
- Forwarding: RD1E=1, ALUResultM=5, ResultW=9. ForwardAE=10 with add of imm 0 gives 5; ForwardAE=01 gives 9; ForwardAE=11 gives 1.
- Branch: beq with equal operands gives PCSrcE=1 and PCTargetE=PCE+ExtImmE. bne with equal operands gives PCSrcE=0. jalr with SrcA=0x1001, imm=2 gives target 0x1002.
- Multiply (EXEC_MUL_EN): 0x12345678 × 0x10 with `MulE` held gives BusyE=1 for exactly 33 cycles, then one DONE cycle with ALUResultE=0x23456780. Wrap case: 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000001.
- Back-to-back `mul` (7×6, then 3×0): results 42 and 0, each after 33 busy cycles, with no cycle lost between them.
- Reset mid-RUN at cycle t+10: BusyE drops to 0 while `rst`=0. After release, the same `mul` completes with a correct result 33 cycles later.
